ahb_slave: RTL and testbench

AHB_SLAVE -- requirements
Module: ahb_slave

---
 rtl/ahb_slave.sv | 121 ++++++++++++
 tb/tb_ahb_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave.sv
// ahb_slave: AHB-Lite register-file slave with 2**ADDR_BITS 32-bit words.
// Define AHB_SLAVE_WAIT_EN to insert one wait state per transfer.
module ahb_slave #(
    parameter int ADDR_BITS = 4
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [31:0] hrdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef AHB_SLAVE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ADDR_BITS-1:0] idx_a;
    logic [ADDR_BITS-1:0] idx_q;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 wr_q;
    logic                 pend_q;
    logic                 accept;
    logic                 wr_done;
    logic                 rd_load;
    logic                 fwd;
    logic [31:0]          mem [DEPTH];
    logic                 unused_addr;

    assign idx_a       = haddr[ADDR_BITS+1:2];
    assign unused_addr = ^{haddr[31:ADDR_BITS+2], haddr[1:0]};

    // A wait cycle holds the bus, so no new address phase can land there.
    assign accept  = hsel && hready && (state_q != S_WAIT);
    assign wr_done = (state_q == S_DATA) && pend_q && wr_q;

    // Reads sample at the address edge, or one edge later with a wait state.
    assign rd_load = WAIT_EN ? ((state_q == S_WAIT) && !wr_q)
                             : (accept && !hwrite);
    assign rd_idx  = WAIT_EN ? idx_q : idx_a;
    assign fwd     = wr_done && (idx_q == rd_idx);

    assign hreadyout = WAIT_EN ? (state_q != S_WAIT) : 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_EN) state_d = S_WAIT;
                    else         state_d = S_DATA;
                end
            end
            S_WAIT: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (accept) begin
                    if (WAIT_EN) state_d = S_WAIT;
                    else         state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pend_q <= 1'b1;
                idx_q  <= idx_a;
                wr_q   <= hwrite;
            end else if (state_q == S_DATA) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_done) begin
            mem[idx_q] <= hwdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata <= '0;
        end else if (rd_load) begin
            hrdata <= fwd ? hwdata : mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_ahb_slave.sv
// tb_ahb_slave: randomized AHB traffic against a transfer-level memory model,
// plus directed scenarios with literal expectations.
module tb_ahb_slave;

    localparam int AB    = 4;
    localparam int DEPTH = 16;
`ifdef AHB_SLAVE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
    localparam logic [31:0] RDY_AFTER_ACC = 32'd0;
`else
    localparam bit WAIT_EN = 1'b0;
    localparam logic [31:0] RDY_AFTER_ACC = 32'd1;
`endif

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    always #5 hclk = ~hclk;

    ahb_slave #(.ADDR_BITS(AB)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hready    (hready),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hrdata    (hrdata)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mmem [DEPTH];
    logic [31:0] exp_rd;
    bit          exp_ready;
    bit          dp_valid;
    bit          dp_write;
    bit          dp_wait;
    int          dp_idx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        exp_rd    = '0;
        exp_ready = 1'b1;
        dp_valid  = 1'b0;
        dp_write  = 1'b0;
        dp_wait   = 1'b0;
        dp_idx    = 0;
    endtask

    // One bus cycle: drive, predict the post-edge outputs, then compare.
    task automatic cycle(input bit sel, input logic [31:0] addr, input bit wr,
                         input bit rdy, input logic [31:0] wd);
        int          ix;
        bit          acc;
        bit          ends;
        logic [31:0] nrd;
        hsel   = sel;
        haddr  = addr;
        hwrite = wr;
        hready = rdy;
        hwdata = wd;
        ix   = int'(addr[AB+1:2]);
        acc  = sel && rdy && !(dp_valid && dp_wait);
        ends = dp_valid && !dp_wait;
        nrd  = exp_rd;
        if (ends && dp_write) mmem[dp_idx] = wd;
        if (WAIT_EN) begin
            if (dp_valid && dp_wait && !dp_write) nrd = mmem[dp_idx];
        end else if (acc && !wr) begin
            nrd = mmem[ix];
        end
        if (acc) begin
            dp_valid = 1'b1;
            dp_write = wr;
            dp_idx   = ix;
            dp_wait  = WAIT_EN;
        end else if (dp_valid && dp_wait) begin
            dp_wait = 1'b0;
        end else if (ends) begin
            dp_valid = 1'b0;
        end
        @(posedge hclk);
        exp_rd    = nrd;
        exp_ready = !(dp_valid && dp_wait);
        @(negedge hclk);
        chk("hreadyout", {31'b0, hreadyout}, {31'b0, exp_ready});
        chk("hrdata", hrdata, exp_rd);
    endtask

    task automatic single(input bit wr, input logic [31:0] addr,
                          input logic [31:0] d);
        cycle(1'b1, addr, wr, 1'b1, $urandom);
        if (WAIT_EN) cycle(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, d);
    endtask

    initial begin
        bit rdy;
        hresetn = 1'b0;
        hsel    = 1'b0;
        haddr   = '0;
        hwrite  = 1'b0;
        hready  = 1'b1;
        hwdata  = '0;
        model_reset();
        repeat (3) @(negedge hclk);
        chk("reset_rdy", {31'b0, hreadyout}, 32'd1);
        chk("reset_rd", hrdata, 32'h0);
        hresetn = 1'b1;

        single(1'b1, 32'h08, 32'hDEADBEEF);
        single(1'b0, 32'h08, 32'h0);
        chk("wr_rd_08", hrdata, 32'hDEADBEEF);

        cycle(1'b0, 32'h0C, 1'b1, 1'b1, $urandom);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
        single(1'b0, 32'h0C, 32'h0);
        chk("nosel_wr", hrdata, 32'h0);

        cycle(1'b1, 32'h04, 1'b1, 1'b1, $urandom);
        if (WAIT_EN) cycle(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        cycle(1'b1, 32'h04, 1'b0, 1'b1, 32'h11111111);
        if (WAIT_EN) cycle(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
        chk("b2b_fwd", hrdata, 32'h11111111);

        single(1'b1, 32'h40, 32'hA5A5A5A5);
        single(1'b0, 32'h00, 32'h0);
        chk("alias", hrdata, 32'hA5A5A5A5);

        chk("rdy_pre", {31'b0, hreadyout}, 32'd1);
        cycle(1'b1, 32'h14, 1'b1, 1'b1, $urandom);
        chk("rdy_a", {31'b0, hreadyout}, RDY_AFTER_ACC);
        cycle(1'b1, 32'h18, 1'b1, 1'b0, WAIT_EN ? $urandom : 32'h77);
        chk("rdy_b", {31'b0, hreadyout}, 32'd1);
        if (WAIT_EN) cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
        chk("rdy_c", {31'b0, hreadyout}, 32'd1);
        single(1'b0, 32'h18, 32'h0);
        chk("ign_hready0", hrdata, 32'h0);
        single(1'b0, 32'h14, 32'h0);
        chk("wr_14", hrdata, 32'h77);

        cycle(1'b1, 32'h10, 1'b1, 1'b1, $urandom);
        if (WAIT_EN) cycle(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        hsel   = 1'b0;
        hready = 1'b1;
        hwdata = 32'hCAFEF00D;
        #1 hresetn = 1'b0;
        #1;
        chk("rst_mid_rdy", {31'b0, hreadyout}, 32'd1);
        chk("rst_mid_rd", hrdata, 32'h0);
        model_reset();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        single(1'b0, 32'h10, 32'h0);
        chk("rst_wr_lost", hrdata, 32'h0);
        single(1'b0, 32'h14, 32'h0);
        chk("rst_mem_clr", hrdata, 32'h0);

        repeat (3000) begin
            rdy = (dp_valid && dp_wait) ? 1'b0 : ($urandom_range(0, 7) != 0);
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 1) != 0, rdy, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
